// File: rtl/if_id_queue.sv
// Circular instruction queue between fetch and decode.
// Fetch side is valid/ready; decode side sees the head entry or a NOP filler.
module if_id_queue #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int DEPTH = 2,
  parameter logic [DW-1:0] NOP = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [DW-1:0]            inst_i,
  input  logic [AW-1:0]            instaddr_i,
  input  logic                     prdct_taken_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [DW-1:0]            inst_o,
  output logic [AW-1:0]            instaddr_o,
  output logic                     prdct_taken_o,
  output logic                     out_valid_o,
  input  logic [4:0]               hold_en_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [DW-1:0] inst;
    logic [AW-1:0] addr;
    logic          taken;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          unused_hold;

  assign unused_hold = ^{hold_en_i[4:2], hold_en_i[0]};

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  assign in_ready_o  = !full;
  assign out_valid_o = !empty;

  assign push = in_valid_i & in_ready_o & !flush_i;
  assign pop  = out_valid_o & !hold_en_i[1] & !flush_i;

  assign head = mem[rd_ptr];

  assign inst_o        = empty ? NOP : head.inst;
  assign instaddr_o    = empty ? '0 : head.addr;
  assign prdct_taken_o = empty ? 1'b0 : head.taken;
  assign count_o       = count;

  // storage carries no reset; validity comes from count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{inst: inst_i,
                       addr: instaddr_i,
                       taken: prdct_taken_i};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        push & !pop: count <= count + (PW+1)'(1);
        pop & !push: count <= count - (PW+1)'(1);
        default:     count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: DEPTH=2 and DEPTH=4 instances on shared stimulus,
// compared each cycle against a queue-based reference model.
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        t;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] inst_i;
  logic [31:0] addr_i;
  logic        t_i;
  logic        in_valid;
  logic [4:0]  hold;
  logic        flush;

  logic [31:0] inst2, inst4, addr2, addr4;
  logic        t2, t4, v2, v4, r2, r4;
  logic [1:0]  c2;
  logic [2:0]  c4;

  int checks = 0;
  int failures = 0;

  ent_t mq [2][$];
  int   mdep [2] = '{2, 4};

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(2)) dut2 (
    .clk(clk), .rstn(rstn),
    .inst_i(inst_i), .instaddr_i(addr_i), .prdct_taken_i(t_i),
    .in_valid_i(in_valid), .in_ready_o(r2),
    .inst_o(inst2), .instaddr_o(addr2), .prdct_taken_o(t2),
    .out_valid_o(v2), .hold_en_i(hold), .flush_i(flush),
    .count_o(c2)
  );

  if_id_queue #(.DEPTH(4)) dut4 (
    .clk(clk), .rstn(rstn),
    .inst_i(inst_i), .instaddr_i(addr_i), .prdct_taken_i(t_i),
    .in_valid_i(in_valid), .in_ready_o(r4),
    .inst_o(inst4), .instaddr_o(addr4), .prdct_taken_o(t4),
    .out_valid_o(v4), .hold_en_i(hold), .flush_i(flush),
    .count_o(c4)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_one(int k, logic [31:0] inst, logic [31:0] addr,
                         logic t, logic v, logic r, int cnt);
    bit   ne;
    ent_t h;
    ne = mq[k].size() != 0;
    h  = ne ? mq[k][0] : '0;
    chk($sformatf("inst_d%0d", mdep[k]), inst, ne ? h.inst : NOP);
    chk($sformatf("addr_d%0d", mdep[k]), addr, ne ? h.addr : 32'h0);
    chk($sformatf("prdct_d%0d", mdep[k]), t, ne ? h.t : 1'b0);
    chk($sformatf("valid_d%0d", mdep[k]), v, ne);
    chk($sformatf("ready_d%0d", mdep[k]), r, mq[k].size() < mdep[k]);
    chk($sformatf("count_d%0d", mdep[k]), cnt, mq[k].size());
  endtask

  task automatic check_all();
    chk_one(0, inst2, addr2, t2, v2, r2, int'(c2));
    chk_one(1, inst4, addr4, t4, v4, r4, int'(c4));
  endtask

  // one clock of the reference: the queue as a bounded FIFO
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit rdy;
      bit vld;
      rdy = mq[k].size() < mdep[k];
      vld = mq[k].size() > 0;
      if (flush) begin
        mq[k].delete();
      end else begin
        if (vld && !hold[1]) void'(mq[k].pop_front());
        if (in_valid && rdy) mq[k].push_back('{inst_i, addr_i, t_i});
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic offer(logic [31:0] a);
    in_valid = 1'b1;
    addr_i   = a;
    inst_i   = 32'h1000_0000 | a;
    t_i      = a[2];
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; hold = '0; flush = 1'b0;
    inst_i = '0; addr_i = '0; t_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rstn = 1'b1;
    cycle();

    // fill then reset mid-stream
    offer(32'h40); cycle();
    offer(32'h44); hold = 5'b00010; cycle();
    chk("pre_reset_count", c2, 2'd2);
    rstn = 1'b0;
    #1;
    mq[0].delete(); mq[1].delete();
    check_all();
    chk("rst_inst", inst2, NOP);
    chk("rst_count", c2, 2'd0);
    chk("rst_ready", r2, 1'b1);
    in_valid = 1'b0; hold = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    cycle();
    chk("post_rst_valid", v2, 1'b0);

    // single pass
    in_valid = 1'b1; inst_i = 32'h00500093; addr_i = 32'h4; t_i = 1'b1;
    cycle();
    chk("sp_inst", inst2, 32'h00500093);
    chk("sp_addr", addr2, 32'h4);
    chk("sp_prdct", t2, 1'b1);
    chk("sp_valid", v2, 1'b1);
    chk("sp_count", c2, 2'd1);
    in_valid = 1'b0;
    cycle();
    chk("sp_pop_count", c2, 2'd0);

    // fill under hold, fetch holds third entry until accepted
    hold = 5'b00010;
    offer(32'hA0); cycle();
    offer(32'hA4); cycle();
    chk("fh_count", c2, 2'd2);
    chk("fh_ready", r2, 1'b0);
    offer(32'hA8); cycle();
    chk("fh_head", inst2, 32'h1000_00A0);
    hold = '0;
    cycle();
    chk("fh_a4", inst2, 32'h1000_00A4);
    cycle();
    chk("fh_a8", inst2, 32'h1000_00A8);
    in_valid = 1'b0;
    repeat (4) cycle();

    // wrap-around stream with push and pop each cycle
    offer(32'h100); cycle();
    for (int i = 1; i <= 10; i++) begin
      offer(32'h100 + 32'(i * 4));
      cycle();
      chk("wrap_count_d4", c4, 3'd1);
    end
    in_valid = 1'b0;
    cycle();

    // flush beats hold and a concurrent push
    hold = 5'b00010;
    offer(32'h200); cycle();
    offer(32'h204); cycle();
    chk("fl_pre_count", c2, 2'd2);
    flush = 1'b1; offer(32'h208);
    cycle();
    chk("fl_count", c2, 2'd0);
    chk("fl_valid", v2, 1'b0);
    chk("fl_inst", inst2, NOP);
    flush = 1'b0; in_valid = 1'b0; hold = '0;
    cycle();
    chk("fl_not_stored", c4, 3'd0);

    // simultaneous push and pop at count 1
    offer(32'h300); cycle();
    chk("pp_ready_before", r2, 1'b1);
    offer(32'h304); cycle();
    chk("pp_count", c2, 2'd1);
    chk("pp_ready", r2, 1'b1);
    chk("pp_head", addr2, 32'h304);
    in_valid = 1'b0;
    cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      inst_i   = $urandom;
      addr_i   = $urandom & 32'hffff_fffc;
      t_i      = 1'($urandom);
      hold     = 5'($urandom);
      if ($urandom_range(0, 2) != 0) hold[1] = 1'b0;
      flush    = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
